gpmc_target: RTL and testbench

//  GPMC responder: FPGA end of the BeagleBone host bus (async, 16-bit muxed A/D, one chip select).

---
 rtl/gpmc_pkg.sv | 18 +
 rtl/gpmc_sync.sv | 47 ++++
 rtl/gpmc_target.sv | 154 +++++++++++++++
 tb/tb_gpmc_target.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/gpmc_pkg.sv
// Shared types and defaults for the GPMC responder: FSM state encoding, bus width,
// synchroniser depth and watchdog timeout.
package gpmc_pkg;

  localparam int AD_W               = 16;
  localparam int SYNC_STAGES_DEF    = 2;
  localparam int TIMEOUT_CYCLES_DEF = 4096;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4,
    ST_RDDRV = 3'd5
  } gpmc_state_e;

endpackage

// File: rtl/gpmc_sync.sv
// N-stage synchroniser bank for the four GPMC strobes plus the muxed A/D bus.
// All lanes share one delay line so data stays aligned with its strobes.
module gpmc_sync
  import gpmc_pkg::*;
#(
  parameter int N = SYNC_STAGES_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            csn_i,
  input  logic            advn_i,
  input  logic            wein_i,
  input  logic            oen_i,
  input  logic [AD_W-1:0] ad_i,
  output logic            csn_o,
  output logic            advn_o,
  output logic            wein_o,
  output logic            oen_o,
  output logic [AD_W-1:0] ad_o
);

  localparam int BW = AD_W + 4;
  // Strobes reset to their inactive (high) level so no false edge appears after reset.
  localparam logic [BW-1:0] RST_VAL = {4'hF, {AD_W{1'b0}}};

  logic [BW-1:0] stage_q [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) stage_q[gi] <= RST_VAL;
          else        stage_q[gi] <= {csn_i, advn_i, wein_i, oen_i, ad_i};
        end
      end else begin : g_rest
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) stage_q[gi] <= RST_VAL;
          else        stage_q[gi] <= stage_q[gi-1];
        end
      end
    end
  endgenerate

  assign {csn_o, advn_o, wein_o, oen_o, ad_o} = stage_q[N-1];

endmodule

// File: rtl/gpmc_target.sv
// GPMC responder (async, 16-bit muxed A/D, one chip select) turning host cycles into
// single-cycle register strobes. Optional watchdog abort: define GPMC_WATCHDOG_EN.
module gpmc_target
  import gpmc_pkg::*;
#(
  parameter int SYNC_STAGES    = SYNC_STAGES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic            clk_100M,
  input  logic            reset_n,
  input  logic [AD_W-1:0] gpmc_ad_in,
  output logic [AD_W-1:0] gpmc_ad_out,
  output logic            gpmc_ad_oe,
  input  logic            gpmc_advn,
  input  logic            gpmc_csn1,
  input  logic            gpmc_wein,
  input  logic            gpmc_oen,
  output logic [AD_W-1:0] reg_addr,
  output logic [AD_W-1:0] reg_wdata,
  output logic            reg_wr,
  output logic            reg_rd,
  input  logic [AD_W-1:0] reg_rdata,
  output logic            bus_err
);

  logic            csn_s, advn_s, wein_s, oen_s;
  logic [AD_W-1:0] ad_s;
  logic            csn_p_q, advn_p_q, wein_p_q, oen_p_q;
  logic [AD_W-1:0] ad_p_q;
  logic            oe_q;
  gpmc_state_e     state_q;
  logic            wd_hit;

  gpmc_sync #(.N(SYNC_STAGES)) u_sync (
    .clk    (clk_100M),
    .rst_n  (reset_n),
    .csn_i  (gpmc_csn1),
    .advn_i (gpmc_advn),
    .wein_i (gpmc_wein),
    .oen_i  (gpmc_oen),
    .ad_i   (gpmc_ad_in),
    .csn_o  (csn_s),
    .advn_o (advn_s),
    .wein_o (wein_s),
    .oen_o  (oen_s),
    .ad_o   (ad_s)
  );

  wire csn_rise  = csn_s  & ~csn_p_q;
  wire advn_rise = advn_s & ~advn_p_q;
  wire wein_rise = wein_s & ~wein_p_q;
  wire wein_fall = ~wein_s & wein_p_q;
  wire oen_rise  = oen_s  & ~oen_p_q;
  wire oen_fall  = ~oen_s & oen_p_q;

  // Bus-fight guard: the pad is only driven while the host is actually reading us.
  assign gpmc_ad_oe = oe_q & ~csn_s & ~oen_s;

`ifdef GPMC_WATCHDOG_EN
  localparam int WD_W = ($clog2(TIMEOUT_CYCLES + 1) > 12) ? $clog2(TIMEOUT_CYCLES + 1) : 12;
  logic [WD_W-1:0] wd_q;

  always_ff @(posedge clk_100M or negedge reset_n) begin
    if (!reset_n)                wd_q <= '0;
    else if (state_q == ST_IDLE) wd_q <= '0;
    else                         wd_q <= wd_q + 1'b1;
  end

  assign wd_hit = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
`else
  assign wd_hit = 1'b0;
`endif

  always_ff @(posedge clk_100M or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      csn_p_q     <= 1'b1;
      advn_p_q    <= 1'b1;
      wein_p_q    <= 1'b1;
      oen_p_q     <= 1'b1;
      ad_p_q      <= '0;
      reg_addr    <= '0;
      reg_wdata   <= '0;
      reg_wr      <= 1'b0;
      reg_rd      <= 1'b0;
      gpmc_ad_out <= '0;
      oe_q        <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      csn_p_q  <= csn_s;
      advn_p_q <= advn_s;
      wein_p_q <= wein_s;
      oen_p_q  <= oen_s;
      ad_p_q   <= ad_s;
      reg_wr   <= 1'b0;
      reg_rd   <= 1'b0;
      if (csn_rise) begin
        // A write whose WE and CS deassert in the same sample still completes.
        state_q <= ST_IDLE;
        oe_q    <= 1'b0;
        if (state_q == ST_WRITE && wein_rise) begin
          reg_wdata <= ad_p_q;
          reg_wr    <= 1'b1;
        end
        if (state_q == ST_ADDR) bus_err <= 1'b1;
      end else if (wd_hit) begin
        state_q <= ST_IDLE;
        oe_q    <= 1'b0;
        bus_err <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: if (!csn_s && !advn_s) state_q <= ST_ADDR;
          ST_ADDR: if (advn_rise) begin
            reg_addr <= ad_p_q;
            state_q  <= ST_WAIT;
          end
          ST_WAIT: begin
            if (!advn_s)               state_q <= ST_ADDR;
            else if (!wein_s && !oen_s) bus_err <= 1'b1;
            else if (wein_fall)        state_q <= ST_WRITE;
            else if (oen_fall) begin
              reg_rd  <= 1'b1;
              state_q <= ST_READ;
            end
          end
          ST_WRITE: if (wein_rise) begin
            reg_wdata <= ad_p_q;
            reg_wr    <= 1'b1;
            state_q   <= ST_WAIT;
          end
          ST_READ: begin
            if (!advn_s) state_q <= ST_ADDR;
            else begin
              gpmc_ad_out <= reg_rdata;
              oe_q        <= 1'b1;
              state_q     <= ST_RDDRV;
            end
          end
          ST_RDDRV: begin
            if (!advn_s) begin
              oe_q    <= 1'b0;
              state_q <= ST_ADDR;
            end else if (oen_rise) begin
              oe_q    <= 1'b0;
              state_q <= ST_WAIT;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gpmc_target.sv
// Directed bench for gpmc_target: write, read, simultaneous CS/WE release, WE+OE conflict,
// reset during read drive, and the csn-held-low watchdog behaviour.
module tb_gpmc_target;

  logic        clk_100M = 1'b0;
  logic        reset_n  = 1'b0;
  logic [15:0] gpmc_ad_in = 16'h0;
  logic [15:0] gpmc_ad_out;
  logic        gpmc_ad_oe;
  logic        gpmc_advn = 1'b1;
  logic        gpmc_csn1 = 1'b1;
  logic        gpmc_wein = 1'b1;
  logic        gpmc_oen  = 1'b1;
  logic [15:0] reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_wr;
  logic        reg_rd;
  logic [15:0] reg_rdata = 16'hCAFE;
  logic        bus_err;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;

  always #5 clk_100M = ~clk_100M;

  gpmc_target #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(64)) dut (
    .clk_100M    (clk_100M),
    .reset_n     (reset_n),
    .gpmc_ad_in  (gpmc_ad_in),
    .gpmc_ad_out (gpmc_ad_out),
    .gpmc_ad_oe  (gpmc_ad_oe),
    .gpmc_advn   (gpmc_advn),
    .gpmc_csn1   (gpmc_csn1),
    .gpmc_wein   (gpmc_wein),
    .gpmc_oen    (gpmc_oen),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_wr      (reg_wr),
    .reg_rd      (reg_rd),
    .reg_rdata   (reg_rdata),
    .bus_err     (bus_err)
  );

  always @(negedge clk_100M) begin
    if (reg_wr) begin
      wr_cnt++;
      $display("write addr=%h data=%h", reg_addr, reg_wdata);
    end
    if (reg_rd) begin
      rd_cnt++;
      $display("read  addr=%h", reg_addr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_100M);
  endtask

  task automatic addr_phase(input logic [15:0] a);
    gpmc_csn1  = 1'b0;
    gpmc_advn  = 1'b0;
    gpmc_ad_in = a;
    cyc(4);
    gpmc_advn = 1'b1;
    cyc(4);
  endtask

  task automatic write_phase(input logic [15:0] d);
    gpmc_ad_in = d;
    gpmc_wein  = 1'b0;
    cyc(4);
    gpmc_wein = 1'b1;
    cyc(4);
  endtask

  task automatic end_access();
    gpmc_csn1 = 1'b1;
    cyc(4);
  endtask

  int wr0, rd0;
  logic oe_seen;

  initial begin
    cyc(3);
    chk("rst_addr",  {16'h0, reg_addr}, 32'h0);
    chk("rst_wdata", {16'h0, reg_wdata}, 32'h0);
    chk("rst_adout", {16'h0, gpmc_ad_out}, 32'h0);
    chk("rst_wr",    {31'h0, reg_wr}, 32'h0);
    chk("rst_rd",    {31'h0, reg_rd}, 32'h0);
    chk("rst_oe",    {31'h0, gpmc_ad_oe}, 32'h0);
    chk("rst_err",   {31'h0, bus_err}, 32'h0);
    reset_n = 1'b1;
    cyc(3);

    // Plain write
    wr0 = wr_cnt;
    addr_phase(16'h0012);
    write_phase(16'hBEEF);
    end_access();
    chk("t1_wr_cnt", wr_cnt - wr0, 1);
    chk("t1_addr",   {16'h0, reg_addr}, 32'h0012);
    chk("t1_wdata",  {16'h0, reg_wdata}, 32'hBEEF);

    // Plain read: strobe 3 edges after oen falls, pad driven one edge later
    rd0 = rd_cnt;
    addr_phase(16'h0034);
    gpmc_oen = 1'b0;
    cyc(3);
    chk("t2_rd_strobe", {31'h0, reg_rd}, 32'h1);
    chk("t2_oe_early",  {31'h0, gpmc_ad_oe}, 32'h0);
    cyc(5);
    chk("t2_oe_drive",  {31'h0, gpmc_ad_oe}, 32'h1);
    chk("t2_adout",     {16'h0, gpmc_ad_out}, 32'hCAFE);
    gpmc_oen = 1'b1;
    cyc(1);
    chk("t2_oe_hold",   {31'h0, gpmc_ad_oe}, 32'h1);
    cyc(1);
    chk("t2_oe_off",    {31'h0, gpmc_ad_oe}, 32'h0);
    end_access();
    chk("t2_rd_cnt", rd_cnt - rd0, 1);

    // CS and WE released together: write still lands, then back to IDLE
    wr0 = wr_cnt;
    addr_phase(16'h0056);
    gpmc_ad_in = 16'h1234;
    gpmc_wein  = 1'b0;
    cyc(4);
    gpmc_wein = 1'b1;
    gpmc_csn1 = 1'b1;
    cyc(4);
    chk("t3_wr_cnt", wr_cnt - wr0, 1);
    chk("t3_wdata",  {16'h0, reg_wdata}, 32'h1234);
    gpmc_csn1 = 1'b0;
    cyc(4);
    write_phase(16'h7777);
    end_access();
    chk("t3_idle_no_wr", wr_cnt - wr0, 1);

    // csn held low for 100 cycles, then a write attempt
    wr0 = wr_cnt;
    addr_phase(16'h0078);
    cyc(100);
    write_phase(16'h0A0A);
    end_access();
`ifdef GPMC_WATCHDOG_EN
    chk("t6_wr_cnt", wr_cnt - wr0, 0);
    chk("t6_err",    {31'h0, bus_err}, 32'h1);
`else
    chk("t6_wr_cnt", wr_cnt - wr0, 1);
    chk("t6_err",    {31'h0, bus_err}, 32'h0);
`endif

    // WE and OE low together: protocol error, no strobes, pad stays off
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    oe_seen = 1'b0;
    addr_phase(16'h009A);
    gpmc_wein = 1'b0;
    gpmc_oen  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      oe_seen = oe_seen | gpmc_ad_oe;
    end
    gpmc_wein = 1'b1;
    gpmc_oen  = 1'b1;
    cyc(4);
    end_access();
    chk("t4_oe",     {31'h0, oe_seen}, 32'h0);
    chk("t4_wr_cnt", wr_cnt - wr0, 0);
    chk("t4_rd_cnt", rd_cnt - rd0, 0);
    chk("t4_err",    {31'h0, bus_err}, 32'h1);

    // Reset while driving read data, then a normal write
    addr_phase(16'h00AB);
    gpmc_oen = 1'b0;
    cyc(6);
    #2 reset_n = 1'b0;
    #1 chk("t5_oe_async", {31'h0, gpmc_ad_oe}, 32'h0);
    chk("t5_err_clr", {31'h0, bus_err}, 32'h0);
    gpmc_oen  = 1'b1;
    gpmc_csn1 = 1'b1;
    cyc(2);
    reset_n = 1'b1;
    cyc(2);
    wr0 = wr_cnt;
    addr_phase(16'h00BC);
    write_phase(16'h5555);
    end_access();
    chk("t5_wr_cnt", wr_cnt - wr0, 1);
    chk("t5_addr",   {16'h0, reg_addr}, 32'h00BC);
    chk("t5_wdata",  {16'h0, reg_wdata}, 32'h5555);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
